mem_burst_tester: RTL and testbench
===================================

Name: mem_burst_tester

Overview:
- Traffic generator and checker sitting directly upstream of the DDR4 burst controller (mem_burst).
- Drives that controller's request side: writes a deterministic pattern burst, reads it back, compares every beat, then advances the address.
- Runs continuously while enabled and exposes sticky error and progress counters to LEDs and ILA.

Parameters:
MEM_DATA_BITS, 64, data width of the controller user port; multiple of 32
ADDR_BITS, 24, burst address width in controller beat units; max 24
BURST_LEN, 128, beats per burst; power of two, 1..512

Ports:
mem_clk  in  1  user-interface clock shared with the burst controller
rst  in  1  asynchronous active-high reset
calib_done  in  1  DDR calibration complete
test_en  in  1  level; run test while high
wr_burst_req  out  1  write burst request to controller
wr_burst_len  out  10  constant BURST_LEN
wr_burst_addr  out  ADDR_BITS  write burst start address
wr_burst_data_req  in  1  controller consumes one beat this cycle
wr_burst_data  out  MEM_DATA_BITS  write beat data
wr_burst_finish  in  1  write burst done pulse
rd_burst_req  out  1  read burst request
rd_burst_len  out  10  constant BURST_LEN
rd_burst_addr  out  ADDR_BITS  read burst start address
rd_burst_data_valid  in  1  read beat valid
rd_burst_data  in  MEM_DATA_BITS  read beat data
rd_burst_finish  in  1  read burst done pulse
busy  out  1  FSM not in IDLE
error  out  1  sticky; any mismatch since reset
error_cnt  out  16  mismatching or missing beats; saturates at 16'hFFFF
pass_cnt  out  32  completed write/read-back pairs; wraps

Behaviour:
- Reset: all outputs are 0, burst_addr is 0, round is 0, and the state is IDLE.
- Clock and reset:
  - rst is asynchronous, active-high; clock is mem_clk.
  - rst mid-burst aborts immediately, with no completion of the current burst.
- Pattern:
  - pat(a,r,k) = 32-bit lane value {r[7:0], (a+k) zero-extended/truncated to 24 bits}, replicated MEM_DATA_BITS/32 times.
  - a = burst_addr, r = round, k = beat index.
- FSM states: IDLE, WRITE, READ, CHECK, NEXT.
  - IDLE -> WRITE when calib_done & test_en. On entry: wr_burst_req=1, wr_idx=0.
  - WRITE: hold wr_burst_req high until the cycle wr_burst_finish is sampled. On that edge, drop wr_burst_req, set rd_burst_req=1, clear rd_idx, and go to READ.
  - READ: hold rd_burst_req until rd_burst_finish. Then drop it and go to CHECK.
  - CHECK (1 cycle):
    - If rd_idx != BURST_LEN, add |BURST_LEN-rd_idx| to error_cnt (saturating) and set error.
    - pass_cnt+1.
    - Go to NEXT.
  - NEXT (1 cycle):
    - burst_addr += BURST_LEN, modulo 2^ADDR_BITS.
    - On wrap to 0, round+1.
    - Go to WRITE if test_en & calib_done, else IDLE.
- Requests never re-assert in the cycle finish is seen, so the controller sees req low when it returns to IDLE.
- Write data:
  - Registered, with 1-cycle latency.
  - On each edge sampling wr_burst_data_req=1 in WRITE: wr_burst_data <= pat(a,r,wr_idx) and wr_idx+1.
  - Data is held otherwise.
  - The k-th request (k from 0) places pat(..,k) on the bus the following cycle. This matches the controller's registered wdf_wren.
  - wr_burst_data_req seen outside WRITE is ignored.
- Read check:
  - On each rd_burst_data_valid in READ, compare against pat(a,r,rd_idx), then rd_idx+1.
  - Mismatch: error_cnt+1 (saturating) and error=1, registered, visible the next cycle.
  - Beats beyond BURST_LEN are each counted as an error.
  - Valid outside READ is ignored.
- Addresses: wr_burst_addr = rd_burst_addr = burst_addr, stable from request until finish.
- test_en dropped mid-pair: finish the current write+read+check, then IDLE.
- calib_done dropped mid-pair: same as test_en dropped.
- Simultaneous data_valid and finish on the last beat: the beat is checked before CHECK evaluates the count.
- error_cnt never wraps.

Decomposition:
- Package mem_test_pkg: state encoding, LANE_BITS=32, ROUND_BITS=8, ERR_CNT_BITS=16.
- One combinational sub-module mem_pattern_gen(a,r,k)->word, instantiated twice: write data and expected read data.

Test Plan:
- Controller model, BURST_LEN=8, ADDR_BITS=10, test_en=1 -> first write beats 0x00000000..0x00000007 per lane at addr 0; read-back clean; pass_cnt=1, error=0, next addr=8.
- Corrupt read beat 3 of pair 2 (flip bit 0) -> error_cnt=1 one cycle after that beat, error sticky, pass_cnt still increments.
- Model returns only 6 valid beats then rd_burst_finish -> error_cnt+=2 in CHECK.
- Run 128 pairs (addr wraps 1016->0) -> round=1; next write beat 0 = 0x01000000 per lane.
- Model stalls wr_burst_data_req (gaps of 3 cycles) -> wr_burst_data changes only one cycle after each req; all reads match.
- Assert rst during READ -> all outputs 0 immediately; after release with test_en=1, restart at addr 0 with round 0.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types, widths and helpers for the memory burst tester.
package mem_test_pkg;

  localparam int unsigned LANE_BITS    = 32;
  localparam int unsigned ROUND_BITS   = 8;
  localparam int unsigned ERR_CNT_BITS = 16;
  localparam int unsigned IDX_BITS     = 16;
  localparam int unsigned LEN_BITS     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_NEXT
  } state_t;

  // Saturating add for the error counter; it must stick at all-ones.
  function automatic logic [ERR_CNT_BITS-1:0] sat_add(
    input logic [ERR_CNT_BITS-1:0] a,
    input logic [ERR_CNT_BITS-1:0] b
  );
    logic [ERR_CNT_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ERR_CNT_BITS] ? '1 : s[ERR_CNT_BITS-1:0];
  endfunction

endpackage

// File: rtl/mem_burst_tester_if.sv
// Request/data bus between the tester (master) and the burst controller (slave).
interface mem_burst_tester_if #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24
);
  logic                     wr_burst_req;
  logic [9:0]               wr_burst_len;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;
  logic                     rd_burst_req;
  logic [9:0]               rd_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );
endinterface

// File: rtl/mem_pattern_gen.sv
// Combinational test pattern: each 32-bit lane is {round, (addr + beat) mod 2^24}.
module mem_pattern_gen
  import mem_test_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24
) (
  input  logic [ADDR_BITS-1:0]     a,
  input  logic [ROUND_BITS-1:0]    r,
  input  logic [IDX_BITS-1:0]      k,
  output logic [MEM_DATA_BITS-1:0] word
);

  logic [23:0] lane_addr;

  // Build one lane and replicate it across the data word.
  always_comb begin
    lane_addr = 24'(a) + 24'(k);
    word      = {(MEM_DATA_BITS / LANE_BITS){r, lane_addr}};
  end

endmodule

// File: rtl/mem_burst_tester.sv
// Write/read-back traffic generator and checker for the DDR burst controller.
module mem_burst_tester
  import mem_test_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned BURST_LEN     = 128
) (
  input  logic                    mem_clk,
  input  logic                    rst,
  input  logic                    calib_done,
  input  logic                    test_en,
  mem_burst_tester_if.master      bus,
  output logic                    busy,
  output logic                    error,
  output logic [ERR_CNT_BITS-1:0] error_cnt,
  output logic [31:0]             pass_cnt
);

  localparam logic [IDX_BITS-1:0]  BL_IDX  = IDX_BITS'(BURST_LEN);
  localparam logic [ADDR_BITS-1:0] BL_ADDR = ADDR_BITS'(BURST_LEN);

  state_t                   state, state_nxt;
  logic                     run;
  logic [ADDR_BITS-1:0]     burst_addr, addr_nxt;
  logic [ROUND_BITS-1:0]    round;
  logic [IDX_BITS-1:0]      wr_idx, rd_idx, len_diff;
  logic [MEM_DATA_BITS-1:0] wr_pat, rd_pat, wr_data;
  logic                     beat_err;

  assign run      = calib_done & test_en;
  assign addr_nxt = burst_addr + BL_ADDR;

  assign bus.wr_burst_len  = LEN_BITS'(BURST_LEN);
  assign bus.rd_burst_len  = LEN_BITS'(BURST_LEN);
  assign bus.wr_burst_addr = burst_addr;
  assign bus.rd_burst_addr = burst_addr;
  assign bus.wr_burst_data = wr_data;

  mem_pattern_gen #(.MEM_DATA_BITS(MEM_DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_wr_pat (
    .a(burst_addr), .r(round), .k(wr_idx), .word(wr_pat)
  );

  mem_pattern_gen #(.MEM_DATA_BITS(MEM_DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_rd_pat (
    .a(burst_addr), .r(round), .k(rd_idx), .word(rd_pat)
  );

  // State register.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; enables are only sampled in IDLE and NEXT so a pair always completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (run) state_nxt = ST_WRITE;
      ST_WRITE: if (bus.wr_burst_finish) state_nxt = ST_READ;
      ST_READ:  if (bus.rd_burst_finish) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = run ? ST_WRITE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Requests decode the registered state, so they drop on the edge that samples finish.
  always_comb begin
    bus.wr_burst_req = (state == ST_WRITE);
    bus.rd_burst_req = (state == ST_READ);
    busy             = (state != ST_IDLE);
  end

  // Write data: one registered pattern word per controller data request.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_data <= '0;
    end else if (state == ST_WRITE) begin
      if (bus.wr_burst_data_req) begin
        wr_data <= wr_pat;
        wr_idx  <= wr_idx + 1'b1;
      end
    end else begin
      wr_idx <= '0;
    end
  end

  // Distance between received beat count and the burst length.
  always_comb begin
    if (rd_idx > BL_IDX) len_diff = rd_idx - BL_IDX;
    else                 len_diff = BL_IDX - rd_idx;
  end

  assign beat_err = (state == ST_READ) && bus.rd_burst_data_valid &&
                    ((rd_idx >= BL_IDX) || (bus.rd_burst_data != rd_pat));

  // Read-back checking, beat-count check and progress counters.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      rd_idx    <= '0;
      error     <= 1'b0;
      error_cnt <= '0;
      pass_cnt  <= '0;
    end else begin
      if (state == ST_WRITE)
        rd_idx <= '0;
      else if ((state == ST_READ) && bus.rd_burst_data_valid && (rd_idx != '1))
        rd_idx <= rd_idx + 1'b1;

      if (beat_err) begin
        error     <= 1'b1;
        error_cnt <= sat_add(error_cnt, ERR_CNT_BITS'(1));
      end

      if (state == ST_CHECK) begin
        pass_cnt <= pass_cnt + 32'd1;
        if (rd_idx != BL_IDX) begin
          error     <= 1'b1;
          error_cnt <= sat_add(error_cnt, len_diff);
        end
      end
    end
  end

  // Burst address advance; the round tag bumps when the address space wraps.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      burst_addr <= '0;
      round      <= '0;
    end else if (state == ST_NEXT) begin
      burst_addr <= addr_nxt;
      if (addr_nxt == '0) round <= round + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_burst_tester.sv
// Bench for mem_burst_tester: behavioural controller/memory model with randomized timing.
module tb_mem_burst_tester;

  localparam int BL    = 8;
  localparam int AB    = 10;
  localparam int ASIZE = 1 << AB;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib_done = 1'b1;
  logic        test_en = 1'b1;
  logic        busy, error;
  logic [15:0] error_cnt;
  logic [31:0] pass_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_addr = 0, exp_round = 0, exp_pass = 0, exp_err = 0;
  logic [63:0] mem [int];
  logic [63:0] first_wbeat;

  mem_burst_tester_if #(.MEM_DATA_BITS(64), .ADDR_BITS(AB)) bus ();

  mem_burst_tester #(.MEM_DATA_BITS(64), .ADDR_BITS(AB), .BURST_LEN(BL)) dut (
    .mem_clk(mem_clk), .rst(rst), .calib_done(calib_done), .test_en(test_en),
    .bus(bus), .busy(busy), .error(error), .error_cnt(error_cnt), .pass_cnt(pass_cnt)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  function automatic logic [63:0] model_pat(input int a, input int r, input int k);
    logic [31:0] lane;
    lane = 32'(((r & 255) << 24) | ((a + k) & 32'h00FF_FFFF));
    return {lane, lane};
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_wr_req", bus.wr_burst_req, 0);
    check_eq("rst_rd_req", bus.rd_burst_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_err_cnt", error_cnt, 0);
    check_eq("rst_pass_cnt", pass_cnt, 0);
    check_eq("rst_wr_data", bus.wr_burst_data, 0);
    check_eq("rst_addr", bus.wr_burst_addr, 0);
  endtask

  // One write/read-back pair. gaps < 0 are randomized; corrupt < 0 means no bad beat;
  // drop_mode 1/2 drops test_en/calib_done mid-pair; rst_at >= 0 resets before that read beat.
  task automatic run_pair(input int wgap, input int rgap, input int corrupt,
                          input int nbeats, input int drop_mode, input int rst_at);
    int t, g, pa, pr;
    logic [63:0] d;
    t = 0;
    while (!bus.wr_burst_req && t < 30) begin tick(); t++; end
    check_eq("wr_req_seen", bus.wr_burst_req, 1);
    if (!bus.wr_burst_req) return;
    check_eq("wr_addr", bus.wr_burst_addr, 64'(exp_addr));
    if (drop_mode == 1) test_en = 1'b0;
    if (drop_mode == 2) calib_done = 1'b0;

    for (int k = 0; k < BL; k++) begin
      bus.wr_burst_data_req = 1'b1;
      tick();
      bus.wr_burst_data_req = 1'b0;
      check_eq("wr_data", bus.wr_burst_data, model_pat(exp_addr, exp_round, k));
      if (k == 0) first_wbeat = bus.wr_burst_data;
      mem[(exp_addr + k) % ASIZE] = model_pat(exp_addr, exp_round, k);
      g = (wgap < 0) ? int'($urandom_range(0, 3)) : wgap;
      for (int j = 0; j < g; j++) begin
        tick();
        check_eq("wr_data_hold", bus.wr_burst_data, model_pat(exp_addr, exp_round, k));
      end
    end
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    check_eq("wr_req_drop", bus.wr_burst_req, 0);
    check_eq("rd_req_rise", bus.rd_burst_req, 1);
    check_eq("rd_addr", bus.rd_burst_addr, 64'(exp_addr));

    for (int k = 0; k < nbeats; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs();
        return;
      end
      if (k < BL) d = mem[(exp_addr + k) % ASIZE];
      else        d = model_pat(exp_addr, exp_round, k);
      if (k == corrupt) d = d ^ 64'd1;
      bus.rd_burst_data       = d;
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_finish     = (k == nbeats - 1);
      tick();
      bus.rd_burst_data_valid = 1'b0;
      bus.rd_burst_finish     = 1'b0;
      if (k == corrupt || k >= BL) exp_err++;
      if (k == corrupt) begin
        check_eq("err_cnt_bad_beat", error_cnt, 64'(exp_err));
        check_eq("error_bad_beat", error, 1);
      end
      if (k != nbeats - 1) begin
        g = (rgap < 0) ? int'($urandom_range(0, 2)) : rgap;
        repeat (g) tick();
      end
    end
    check_eq("rd_req_drop", bus.rd_burst_req, 0);
    tick();
    exp_err += (nbeats > BL) ? nbeats - BL : BL - nbeats;
    exp_pass++;
    check_eq("err_cnt_check", error_cnt, 64'(exp_err));
    check_eq("pass_cnt", pass_cnt, 64'(exp_pass));
    check_eq("error_flag", error, (exp_err != 0) ? 1 : 0);
    tick();
    pa = exp_addr;
    pr = exp_round;
    exp_addr = (exp_addr + BL) % ASIZE;
    if (exp_addr == 0) exp_round++;

    if (drop_mode != 0) begin
      check_eq("idle_after_drop", busy, 0);
      repeat (4) tick();
      check_eq("no_req_idle", bus.wr_burst_req, 0);
      bus.wr_burst_data_req = 1'b1;
      tick();
      bus.wr_burst_data_req = 1'b0;
      check_eq("idle_data_req_ignored", bus.wr_burst_data, model_pat(pa, pr, BL - 1));
      test_en    = 1'b1;
      calib_done = 1'b1;
    end else begin
      check_eq("busy_next_pair", busy, 1);
    end
  endtask

  initial begin
    int pairs, c;
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_finish     = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    check_eq("wr_len", bus.wr_burst_len, BL);
    check_eq("rd_len", bus.rd_burst_len, BL);
    rst = 1'b0;

    run_pair(0, 0, -1, BL, 0, -1);          // clean first pair at addr 0
    check_eq("first_beat_pair1", first_wbeat, 64'h0);
    run_pair(0, 0, 3, BL, 0, -1);           // corrupted beat 3
    run_pair(-1, -1, -1, 6, 0, -1);         // two beats missing
    run_pair(-1, 0, -1, 9, 0, -1);          // one extra beat
    run_pair(3, 0, -1, BL, 0, -1);          // stalled data requests
    run_pair(-1, -1, -1, BL, 1, -1);        // test_en drop mid-pair
    run_pair(-1, -1, -1, BL, 2, -1);        // calib_done drop mid-pair
    pairs = 7;
    while (pairs < ASIZE / BL) begin
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
      run_pair(-1, -1, c, BL, 0, -1);
      pairs++;
    end
    run_pair(-1, -1, -1, BL, 0, -1);        // first pair of round 1
    check_eq("round_wrap_beat0", first_wbeat, 64'h0100_0000_0100_0000);
    check_eq("error_sticky", error, 1);

    run_pair(-1, 0, -1, BL, 0, 3);          // reset during read
    repeat (2) tick();
    rst = 1'b0;
    exp_addr = 0; exp_round = 0; exp_pass = 0; exp_err = 0;
    run_pair(-1, -1, -1, BL, 0, -1);
    check_eq("restart_first_beat", first_wbeat, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
